pc_sequencer: RTL and testbench

//  Multicycle next-PC controller for the MIPS core. Owns the PC register and fetches each

---
 rtl/pc_sequencer_pkg.sv | 15 +
 rtl/pc_sequencer_jump_target_gen.sv | 14 +
 rtl/pc_sequencer.sv | 95 +++++++++
 tb/tb_pc_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: opcode/funct constants and FSM state encoding for the next-PC controller
package pc_sequencer_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;
  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_ISSUE   = 2'd1,
    S_RESOLVE = 2'd2,
    S_HALTED  = 2'd3
  } state_t;
endpackage

// File: rtl/pc_sequencer_jump_target_gen.sv
// jump_target_gen: sequential PC (pc+4) and J/JAL pseudo-direct target
//  pc          in  32  current PC
//  instr_index in  26  instruction jump index field
//  pc4         out 32  pc + 4, wrapping modulo 2^32
//  target      out 32  {pc4[31:28], instr_index, 2'b00}
module jump_target_gen (
  input  logic [31:0] pc,
  input  logic [25:0] instr_index,
  output logic [31:0] pc4,
  output logic [31:0] target
);
  assign pc4    = pc + 32'd4;
  assign target = {pc4[31:28], instr_index, 2'b00};
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle next-PC controller; owns PC, fetches over req/ack, issues to decode
//  clk/rst_n                 clock, asynchronous active-low reset
//  imem_req/addr/ack/rdata   instruction-memory handshake
//  instr_valid/instr/ready   issued instruction to decode
//  br_resolve/taken/target   branch or JR resolution from execute
//  halt                      stop after the issuing instruction
//  pc                        current PC
//  ra_we/ra_wdata            JAL link write pulse
//  fetch_err                 sticky imem timeout flag
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        instr_ready,
  input  logic        br_resolve,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        halt,
  output logic [31:0] pc,
  output logic        ra_we,
  output logic [31:0] ra_wdata,
  output logic        fetch_err
);
  localparam int CW = $clog2(IMEM_TIMEOUT + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] pc4, j_target, pc_nx;
  logic [5:0] op;
  logic is_jr, is_jump, is_res, is_jal_xfer, timeout;
  jump_target_gen u_jt (
    .pc          (pc),
    .instr_index (instr[25:0]),
    .pc4         (pc4),
    .target      (j_target)
  );
  assign op          = instr[31:26];
  assign is_jr       = op == OP_RTYPE && instr[5:0] == FN_JR;
  assign is_jump     = op == OP_J || op == OP_JAL;
  assign is_res      = op == OP_BEQ || op == OP_BNE || is_jr;
  assign is_jal_xfer = state == S_ISSUE && instr_ready && op == OP_JAL;
  // ack in the final allowed cycle still counts as a successful fetch
  assign timeout     = cnt == CW'(IMEM_TIMEOUT - 1) && !imem_ack;
  // request is dropped combinationally while reset is held
  assign imem_req    = rst_n && state == S_FETCH;
  assign imem_addr   = imem_req ? pc : '0;
  assign instr_valid = state == S_ISSUE;
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    case (state)
      S_FETCH:
        state_nx = imem_ack ? S_ISSUE : timeout ? S_HALTED : S_FETCH;
      S_ISSUE:
        if (instr_ready) begin
          pc_nx    = is_res ? pc : is_jump ? j_target : pc4;
          state_nx = is_res ? S_RESOLVE : halt ? S_HALTED : S_FETCH;
        end
      S_RESOLVE:
        if (br_resolve) begin
          pc_nx    = (is_jr || br_taken) ? (br_target & ~32'h3) : pc4;
          state_nx = halt ? S_HALTED : S_FETCH;
        end
      default: state_nx = S_HALTED;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      cnt       <= '0;
      instr     <= '0;
      fetch_err <= 1'b0;
      ra_we     <= 1'b0;
      ra_wdata  <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      cnt   <= (state == S_FETCH && state_nx == S_FETCH) ? cnt + CW'(1) : '0;
      ra_we <= is_jal_xfer;
      if (state == S_FETCH && imem_ack) instr <= imem_rdata;
      if (state == S_FETCH && timeout) fetch_err <= 1'b1;
      if (is_jal_xfer) ra_wdata <= pc4;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven and randomized self-checking bench for pc_sequencer
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  logic clk = 1'b0;
  logic rst_n, imem_req, imem_ack, instr_valid, instr_ready;
  logic br_resolve, br_taken, halt, ra_we, fetch_err;
  logic [31:0] imem_addr, imem_rdata, instr, br_target, pc, ra_wdata;
  int total = 0;
  int pass = 0;
  logic [31:0] cur_pc;
  typedef struct {
    logic [31:0] ins;
    int          dly;
    logic        tk;
    logic [31:0] tgt;
    logic        hlt;
    logic [31:0] exp_pc;
    logic        exp_ra;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl[13];
  always #5 clk = ~clk;
  pc_sequencer #(.RESET_PC(RST_PC), .IMEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .br_resolve(br_resolve), .br_taken(br_taken), .br_target(br_target), .halt(halt),
    .pc(pc), .ra_we(ra_we), .ra_wdata(ra_wdata), .fetch_err(fetch_err)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic bit needs_resolve(input logic [31:0] ins);
    logic [5:0] op = ins[31:26];
    return op == 6'd4 || op == 6'd5 || (op == 6'd0 && ins[5:0] == 6'd8);
  endfunction
  // architectural next PC computed directly from the ISA rules
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                             input logic tk, input logic [31:0] tgt);
    logic [31:0] seq = p + 32'd4;
    int op = int'(ins >> 26);
    if (op == 2 || op == 3) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (op == 0 && (ins & 32'h3F) == 32'd8) return tgt & 32'hFFFF_FFFC;
    if (op == 4 || op == 5) return tk ? (tgt & 32'hFFFF_FFFC) : seq;
    return seq;
  endfunction
  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 0; imem_rdata = 0; instr_ready = 0;
    br_resolve = 0; br_taken = 0; br_target = 0; halt = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_ra_we", ra_we, 0);
    rst_n = 1'b1;
    cur_pc = RST_PC;
    #1;
  endtask
  task automatic run_instr(input logic [31:0] ins, input int dly, input logic tk,
                           input logic [31:0] tgt, input logic hlt, input logic [31:0] exp_pc,
                           input logic exp_ra, input logic [31:0] exp_rd);
    int n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, cur_pc);
    for (int i = 0; i < dly; i++) begin
      br_resolve = 1'($urandom_range(0, 1)); br_taken = 1; br_target = $urandom;
      @(negedge clk);
    end
    br_resolve = 0; br_taken = 0;
    chk("req_hold", imem_req, 1);
    chk("pc_fetch", pc, cur_pc);
    imem_ack = 1; imem_rdata = ins;
    @(negedge clk);
    imem_ack = 0; imem_rdata = $urandom;
    chk("issue_valid", instr_valid, 1);
    chk("issue_instr", instr, ins);
    chk("issue_req", imem_req, 0);
    chk("ra_idle", ra_we, 0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    chk("instr_hold", instr, ins);
    instr_ready = 1; halt = hlt && !needs_resolve(ins);
    @(negedge clk);
    instr_ready = 0; halt = 0;
    if (needs_resolve(ins)) begin
      chk("resolve_pc", pc, cur_pc);
      chk("resolve_valid", instr_valid, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      br_resolve = 1; br_taken = tk; br_target = tgt; halt = hlt;
      @(negedge clk);
      br_resolve = 0; br_taken = 0; halt = 0;
    end
    chk("next_pc", pc, exp_pc);
    chk("ra_we", ra_we, exp_ra);
    if (exp_ra) chk("ra_wdata", ra_wdata, exp_rd);
    chk("req_after", imem_req, hlt ? 0 : 1);
    cur_pc = exp_pc;
  endtask
  task automatic chk_halted(input logic [31:0] exp_pc);
    for (int i = 0; i < 4; i++) begin
      br_resolve = 1; br_taken = 1; br_target = $urandom; instr_ready = 1; imem_ack = 1;
      @(negedge clk);
      chk("halt_req", imem_req, 0);
      chk("halt_valid", instr_valid, 0);
      chk("halt_pc", pc, exp_pc);
    end
    br_resolve = 0; br_taken = 0; instr_ready = 0; imem_ack = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] ins, tgt, nxt;
    logic tk;
    tbl[0]  = '{32'h2001_0005, 2, 0, 32'h0,         0, 32'h0000_0004, 0, 32'h0};
    tbl[1]  = '{32'h03E0_0008, 1, 0, 32'h0FFF_FFFC, 0, 32'h0FFF_FFFC, 0, 32'h0};
    tbl[2]  = '{32'h0800_0010, 3, 0, 32'h0,         0, 32'h1000_0040, 0, 32'h0};
    tbl[3]  = '{32'h03E0_0008, 0, 1, 32'h0000_0101, 0, 32'h0000_0100, 0, 32'h0};
    tbl[4]  = '{32'h0C00_0020, 0, 0, 32'h0,         0, 32'h0000_0080, 1, 32'h0000_0104};
    tbl[5]  = '{32'h03E0_0008, 1, 0, 32'h0000_0200, 0, 32'h0000_0200, 0, 32'h0};
    tbl[6]  = '{32'h1022_0003, 1, 0, 32'h0000_0300, 0, 32'h0000_0204, 0, 32'h0};
    tbl[7]  = '{32'h1022_0003, 2, 1, 32'h0000_0300, 0, 32'h0000_0300, 0, 32'h0};
    tbl[8]  = '{32'h1422_0001, 0, 1, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFC, 0, 32'h0};
    tbl[9]  = '{32'h2001_0005, 3, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0};
    tbl[10] = '{32'h0022_1820, 0, 0, 32'h0,         0, 32'h0000_0004, 0, 32'h0};
    tbl[11] = '{32'h0BFF_FFFF, 1, 0, 32'h0,         0, 32'h0FFF_FFFC, 0, 32'h0};
    tbl[12] = '{32'h2001_0005, 0, 0, 32'h0,         1, 32'h1000_0000, 0, 32'h0};
    do_reset();
    chk("to_req1", imem_req, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to_req_hold", imem_req, 1);
      chk("to_err_low", fetch_err, 0);
    end
    @(negedge clk);
    chk("to_req_drop", imem_req, 0);
    chk("to_err", fetch_err, 1);
    chk_halted(RST_PC);
    chk("to_err_sticky", fetch_err, 1);
    do_reset();
    foreach (tbl[i])
      run_instr(tbl[i].ins, tbl[i].dly, tbl[i].tk, tbl[i].tgt, tbl[i].hlt,
                tbl[i].exp_pc, tbl[i].exp_ra, tbl[i].exp_rd);
    chk("tbl_no_err", fetch_err, 0);
    chk_halted(32'h1000_0000);
    do_reset();
    run_instr(32'h03E0_0008, 0, 0, 32'h0000_0ABE, 1, 32'h0000_0ABC, 0, 32'h0);
    chk_halted(32'h0000_0ABC);
    do_reset();
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 6))
        0: ins = {6'h02, 26'($urandom)};
        1: ins = {6'h03, 26'($urandom)};
        2: ins = {6'h04, 26'($urandom)};
        3: ins = {6'h05, 26'($urandom)};
        4: ins = {6'h00, 20'($urandom), 6'h08};
        5: ins = {6'h00, 20'($urandom), 6'($urandom_range(9, 63))};
        default: ins = {6'($urandom_range(6, 63)), 26'($urandom)};
      endcase
      tk = 1'($urandom_range(0, 1));
      tgt = $urandom;
      nxt = model_next(cur_pc, ins, tk, tgt);
      run_instr(ins, $urandom_range(0, 3), tk, tgt, 0, nxt, ins[31:26] == 6'h03, cur_pc + 32'd4);
    end
    chk("rand_no_err", fetch_err, 0);
    while (cur_pc == RST_PC) begin
      run_instr(32'h2001_0005, 0, 0, 0, 0, cur_pc + 32'd4, 0, 0);
    end
    imem_ack = 1; imem_rdata = 32'h2001_0005;
    @(negedge clk);
    imem_ack = 0;
    chk("pre_rst_valid", instr_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_pc", pc, RST_PC);
    chk("mid_rst_instr", instr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
